// File: rtl/instr_encoder.sv
// Instruction encoder: packs symbolic descriptors into 32-bit instruction words,
// buffers them in a small FIFO and writes them sequentially into instruction memory.

package common;
  typedef logic [4:0]  regid_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [6:0] {
    OP_ADD      = 7'h01,
    OP_SUB      = 7'h02,
    OP_MUL      = 7'h03,
    OP_MOV      = 7'h04,
    OP_ADDI     = 7'h05,
    OP_LDB      = 7'h06,
    OP_LDW      = 7'h07,
    OP_STB      = 7'h08,
    OP_STW      = 7'h09,
    OP_BEQ      = 7'h0A,
    OP_JUMP     = 7'h0B,
    OP_TLBWRITE = 7'h0C,
    OP_IRET     = 7'h0D
  } opcode_t;
endpackage

module instr_encoder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned ADDR_STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  common::opcode_t  in_op,
  input  common::regid_t   in_dst,
  input  common::regid_t   in_src1,
  input  common::regid_t   in_src2,
  input  logic [31:0]      in_imm,
  input  logic             in_tlb_dtlb,
  input  logic             flush,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             err,
  output logic [15:0]      written_count
);
  import common::*;

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W:0] wr_ptr, rd_ptr;
  instr_t         fifo_mem [FIFO_DEPTH];
  logic           fifo_empty, fifo_full;
  logic           ready_q;
  logic           err_q;
  logic [31:0]    addr_q;
  logic [15:0]    count_q;

  instr_t         enc_word;
  logic           enc_legal;
  logic           accept, push, pop;

  // NOTE: every signal written here gets a default first so no path through the
  // case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB, OP_MUL: begin
        enc_word  = {in_op, in_dst, in_src1, in_src2, 10'd0};
        enc_legal = 1'b1;
      end
      OP_MOV: begin
        enc_word  = {in_op, in_dst, in_src1, 5'd0, 10'd0};
        enc_legal = 1'b1;
      end
      OP_ADDI, OP_LDB, OP_LDW: begin
        enc_word  = {in_op, in_dst, in_src1, in_imm[14:0]};
        enc_legal = (in_imm[31:15] == '0);
      end
      // Stores take the base in src1 and the data register from src2,
      // which lands in the dst field of the word.
      OP_STB, OP_STW: begin
        enc_word  = {in_op, in_src2, in_src1, in_imm[14:0]};
        enc_legal = (in_imm[31:15] == '0);
      end
      OP_BEQ: begin
        enc_word  = {in_op, in_imm[14:10], in_src1, in_src2, in_imm[9:0]};
        enc_legal = (in_imm[31:15] == '0);
      end
      OP_JUMP: begin
        enc_word  = {in_op, in_imm[19:15], in_src1, in_imm[14:10], in_imm[9:0]};
        enc_legal = (in_imm[31:20] == '0);
      end
      OP_TLBWRITE: begin
        enc_word  = {in_op, 5'd0, in_src1, in_src2, 9'd0, in_tlb_dtlb};
        enc_legal = 1'b1;
      end
      OP_IRET: begin
        enc_word  = {in_op, 25'd0};
        enc_legal = 1'b1;
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // ready_q keeps in_ready low through reset and releases it one edge later.
  assign in_ready = ready_q && !fifo_full && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc_legal;
  assign mem_we   = !fifo_empty;
  assign pop      = mem_we && mem_ready && !flush;

  assign mem_wdata     = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
  assign mem_addr      = addr_q;
  assign err           = err_q;
  assign written_count = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= accept && !enc_legal;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        addr_q  <= BASE_ADDR;
        count_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          addr_q  <= addr_q + 32'(ADDR_STEP);
          if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and an empty FIFO forces mem_wdata to zero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// descriptors scored against a field-arithmetic reference model.
module tb_instr_encoder;
  import common::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  opcode_t     in_op = OP_ADD;
  regid_t      in_dst = '0, in_src1 = '0, in_src2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_tlb_dtlb = 1'b0;
  logic        flush = 1'b0;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic        err;
  logic [15:0] written_count;

  instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(BASE), .ADDR_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm(in_imm), .in_tlb_dtlb(in_tlb_dtlb), .flush(flush),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .err(err), .written_count(written_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    opcode_t     op;
    int          dst, s1, s2;
    logic [31:0] imm;
    bit          tlb;
  } desc_t;

  int          total_cnt = 0;
  int          pass_cnt = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = BASE;
  logic [15:0] exp_count = '0;

  opcode_t legal_ops[13] = '{OP_ADD, OP_SUB, OP_MUL, OP_MOV, OP_ADDI, OP_LDB, OP_LDW,
                             OP_STB, OP_STW, OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET};

  // Reference model: fields placed by weighted arithmetic from the bit layout.
  function automatic logic [31:0] pack(longint op, longint f1, longint f2, longint f3, longint lo);
    return 32'(op * 33554432 + f1 * 1048576 + f2 * 32768 + f3 * 1024 + lo);
  endfunction

  function automatic bit model_legal(desc_t d);
    longint im = longint'(d.imm);
    case (d.op)
      OP_ADD, OP_SUB, OP_MUL, OP_MOV, OP_TLBWRITE, OP_IRET: return 1'b1;
      OP_ADDI, OP_LDB, OP_LDW, OP_STB, OP_STW, OP_BEQ:      return im < 32768;
      OP_JUMP:                                              return im < 1048576;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_word(desc_t d);
    longint im = longint'(d.imm);
    longint op = longint'(d.op);
    case (d.op)
      OP_ADD, OP_SUB, OP_MUL:  return pack(op, d.dst, d.s1, d.s2, 0);
      OP_MOV:                  return pack(op, d.dst, d.s1, 0, 0);
      OP_ADDI, OP_LDB, OP_LDW: return pack(op, d.dst, d.s1, (im / 1024) % 32, im % 1024);
      OP_STB, OP_STW:          return pack(op, d.s2, d.s1, (im / 1024) % 32, im % 1024);
      OP_BEQ:                  return pack(op, (im / 1024) % 32, d.s1, d.s2, im % 1024);
      OP_JUMP:                 return pack(op, (im / 32768) % 32, d.s1, (im / 1024) % 32, im % 1024);
      OP_TLBWRITE:             return pack(op, 0, d.s1, d.s2, longint'(d.tlb));
      OP_IRET:                 return pack(op, 0, 0, 0, 0);
      default:                 return '0;
    endcase
  endfunction

  function automatic desc_t mk(opcode_t op, int dst, int s1, int s2, logic [31:0] imm, bit tlb);
    desc_t d;
    d.op = op; d.dst = dst; d.s1 = s1; d.s2 = s2; d.imm = imm; d.tlb = tlb;
    return d;
  endfunction

  // Write-port scoreboard: each committed write must match the next expected word/address.
  always @(negedge clk) begin
    if (mon_en) begin
      total_cnt++;
      if (written_count !== exp_count)
        $display("FAIL mon_count: got %0d expected %0d", written_count, exp_count);
      else pass_cnt++;
      if (mem_we && mem_ready && !flush) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL mon_unexpected_write: got %h at %h expected no write", mem_wdata, mem_addr);
        end else begin
          logic [31:0] w;
          w = exp_q.pop_front();
          if (mem_wdata !== w || mem_addr !== exp_addr)
            $display("FAIL mon_write: got %h@%h expected %h@%h", mem_wdata, mem_addr, w, exp_addr);
          else pass_cnt++;
        end
        exp_addr += 32'd4;
        if (exp_count != 16'hFFFF) exp_count++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(desc_t d);
    in_valid = 1'b1; in_op = d.op; in_dst = 5'(d.dst); in_src1 = 5'(d.s1);
    in_src2 = 5'(d.s2); in_imm = d.imm; in_tlb_dtlb = d.tlb;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_accept(desc_t d, bit rand_ready);
    int   n = 0;
    bit   acc = 1'b0;
    logic exp_err;
    exp_err = !model_legal(d);
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        if (model_legal(d)) exp_q.push_back(model_word(d));
      end
      @(posedge clk); #1;
      if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
      n++;
    end
    total_cnt++;
    if (!acc) $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    else if (err !== exp_err) $display("FAIL err_pulse: got %b expected %b (op %h)", err, exp_err, d.op);
    else pass_cnt++;
  endtask

  task automatic send(desc_t d, bit rand_ready);
    drive(d);
    wait_accept(d, rand_ready);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || mem_we) && n < 200) begin
      step();
      n++;
    end
    total_cnt++;
    if (exp_q.size() != 0 || mem_we)
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    exp_addr = BASE;
    exp_count = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 32'd0 || mem_addr !== BASE ||
        err !== 1'b0 || written_count !== 16'd0)
      $display("FAIL reset_state: got rdy=%b we=%b wd=%h a=%h err=%b cnt=%0d expected 0/0/0/%h/0/0",
               in_ready, mem_we, mem_wdata, mem_addr, err, written_count, BASE);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    mon_en = 1'b1;
  endtask

  task automatic test_add();
    mem_ready = 1'b1;
    send(mk(OP_ADD, 3, 1, 2, 0, 0), 0);
    idle();
    total_cnt++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== {OP_ADD, 5'd3, 5'd1, 5'd2, 10'd0})
      $display("FAIL add_word: got we=%b %h@%h expected 1 %h@00001000",
               mem_we, mem_wdata, mem_addr, {OP_ADD, 5'd3, 5'd1, 5'd2, 10'd0});
    else pass_cnt++;
    step();
    total_cnt++;
    if (written_count !== 16'd1 || mem_we !== 1'b0)
      $display("FAIL add_commit: got cnt=%0d we=%b expected 1/0", written_count, mem_we);
    else pass_cnt++;
  endtask

  task automatic test_beq_jump();
    do_flush();
    mem_ready = 1'b0;
    send(mk(OP_BEQ, 0, 4, 5, 32'h4C21, 0), 0);
    send(mk(OP_JUMP, 0, 6, 0, 32'hABCDE, 0), 0);
    idle();
    total_cnt++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h1000 || mem_wdata !== {OP_BEQ, 5'h13, 5'd4, 5'd5, 10'h021})
      $display("FAIL beq_word: got %h@%h expected %h@00001000",
               mem_wdata, mem_addr, {OP_BEQ, 5'h13, 5'd4, 5'd5, 10'h021});
    else pass_cnt++;
    mem_ready = 1'b1;
    step();
    total_cnt++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h1004 || mem_wdata !== {OP_JUMP, 5'h15, 5'd6, 5'h0F, 10'h0DE})
      $display("FAIL jump_word: got %h@%h expected %h@00001004",
               mem_wdata, mem_addr, {OP_JUMP, 5'h15, 5'd6, 5'h0F, 10'h0DE});
    else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_illegal();
    do_flush();
    mem_ready = 1'b1;
    send(mk(OP_ADDI, 1, 2, 0, 32'h8000, 0), 0);
    idle();
    total_cnt++;
    if (mem_we !== 1'b0) $display("FAIL illegal_no_write: got we=%b expected 0", mem_we);
    else pass_cnt++;
    step();
    total_cnt++;
    if (err !== 1'b0) $display("FAIL illegal_err_width: got %b expected 0", err);
    else pass_cnt++;
    send(mk(opcode_t'(7'h7F), 1, 2, 3, 0, 0), 0);
    send(mk(OP_JUMP, 0, 1, 0, 32'h0010_0000, 0), 0);
    send(mk(OP_JUMP, 0, 1, 0, 32'h000F_FFFF, 0), 0);
    idle();
    total_cnt++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h1000 ||
        mem_wdata !== {OP_JUMP, 5'h1F, 5'd1, 5'h1F, 10'h3FF})
      $display("FAIL illegal_then_legal: got %h@%h expected %h@00001000",
               mem_wdata, mem_addr, {OP_JUMP, 5'h1F, 5'd1, 5'h1F, 10'h3FF});
    else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    desc_t d[5];
    do_flush();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) d[i] = mk(OP_SUB, i + 1, i + 10, i + 20, 0, 0);
    for (int i = 0; i < 4; i++) send(d[i], 0);
    drive(d[4]);
    repeat (3) begin
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== BASE || mem_wdata !== model_word(d[0]))
        $display("FAIL full_hold: got rdy=%b we=%b %h@%h expected 0 1 %h@%h",
                 in_ready, mem_we, mem_wdata, mem_addr, model_word(d[0]), BASE);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    wait_accept(d[4], 0);
    idle();
    wait_drain();
    total_cnt++;
    if (written_count !== 16'd5 || mem_addr !== 32'h1014)
      $display("FAIL drain5: got cnt=%0d a=%h expected 5 00001014", written_count, mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_tlb_iret();
    do_flush();
    mem_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      send(mk(OP_TLBWRITE, 31, 7, 9, 32'hFFFF_FFFF, 1'(t)), 0);
      idle();
      total_cnt++;
      if (mem_wdata !== {OP_TLBWRITE, 5'd0, 5'd7, 5'd9, 9'd0, 1'(t)})
        $display("FAIL tlb_word%0d: got %h expected %h", t, mem_wdata,
                 {OP_TLBWRITE, 5'd0, 5'd7, 5'd9, 9'd0, 1'(t)});
      else pass_cnt++;
      mem_ready = 1'b1;
      wait_drain();
      mem_ready = 1'b0;
    end
    send(mk(OP_IRET, 31, 31, 31, 32'hFFFF_FFFF, 1), 0);
    idle();
    total_cnt++;
    if (mem_wdata !== {OP_IRET, 25'd0})
      $display("FAIL iret_word: got %h expected %h", mem_wdata, {OP_IRET, 25'd0});
    else pass_cnt++;
    mem_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_flush();
    do_flush();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(OP_MOV, i, i + 1, 0, 0, 0), 0);
    flush = 1'b1;
    mem_ready = 1'b1;
    drive(mk(OP_ADD, 9, 9, 9, 0, 0));
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    exp_q.delete();
    exp_addr = BASE;
    exp_count = '0;
    total_cnt++;
    if (mem_we !== 1'b0 || mem_addr !== BASE || written_count !== 16'd0 || err !== 1'b0)
      $display("FAIL flush_state: got we=%b a=%h cnt=%0d err=%b expected 0 %h 0 0",
               mem_we, mem_addr, written_count, err, BASE);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    send(mk(OP_ADD, 1, 1, 1, 0, 0), 0);
    send(mk(OP_ADD, 2, 2, 2, 0, 0), 0);
    idle();
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 32'd0 || mem_addr !== BASE ||
        err !== 1'b0 || written_count !== 16'd0)
      $display("FAIL reset_mid: got rdy=%b we=%b wd=%h a=%h err=%b cnt=%0d expected 0/0/0/%h/0/0",
               in_ready, mem_we, mem_wdata, mem_addr, err, written_count, BASE);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_addr = BASE;
    exp_count = '0;
    step();
    mon_en = 1'b1;
    mem_ready = 1'b1;
    send(mk(OP_MUL, 4, 5, 6, 0, 0), 0);
    idle();
    wait_drain();
  endtask

  task automatic test_random();
    do_flush();
    for (int i = 0; i < 80; i++) begin
      desc_t d;
      int    sel;
      sel = int'($urandom_range(0, 15));
      d.op = (sel < 13) ? legal_ops[sel] : opcode_t'(7'($urandom_range(14, 127)));
      d.dst = int'($urandom_range(0, 31));
      d.s1 = int'($urandom_range(0, 31));
      d.s2 = int'($urandom_range(0, 31));
      d.tlb = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d.imm = $urandom & 32'h7FFF;
        1: d.imm = $urandom & 32'hF_FFFF;
        2: d.imm = $urandom;
        default: begin
          logic [31:0] edges[4];
          edges = '{32'h7FFF, 32'h8000, 32'hF_FFFF, 32'h10_0000};
          d.imm = edges[$urandom_range(0, 3)];
        end
      endcase
      send(d, 1);
    end
    idle();
    mem_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_beq_jump();
    test_illegal();
    test_back_to_back();
    test_tlb_iret();
    test_flush();
    test_reset_mid();
    test_random();
    repeat (2) step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
